// File: rtl/rv32_ctrl_pkg.sv
// Shared definitions for the RV32I execute-stage pipeline controller.
//   - funct3 encodings of the B-type instructions
//   - operand forwarding select encodings
//   - controller FSM state type
//   - fwd_hit(): "this stage writes a non-x0 register that matches this source"
package rv32_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StRun   = 2'b01,
    StFlush = 2'b10
  } ctrl_state_e;

  function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/br_resolve.sv
// Combinational branch resolution for the RV32I comparator.
//   funct3_i  : B-type funct3 of the EX instruction
//   br_eq_i   : comparator equal flag
//   br_lt_i   : comparator less-than flag (signed or unsigned per br_un_o)
//   taken_o   : branch condition holds
//   br_un_o   : comparator unsigned mode (funct3[1])
//   illegal_o : funct3 is not a defined B-type encoding (010/011)
module br_resolve
  import rv32_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  output logic       taken_o,
  output logic       br_un_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    br_un_o   = funct3_i[1];
    case (funct3_i)
      F3_BEQ:           taken_o = br_eq_i;
      F3_BNE:           taken_o = ~br_eq_i;
      F3_BLT, F3_BLTU:  taken_o = br_lt_i;
      F3_BGE, F3_BGEU:  taken_o = ~br_lt_i;
      default:          illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// RV32I execute-stage pipeline controller.
// Resolves branches/jumps in EX, selects ALU operand forwarding, detects load-use
// hazards, drives stall/flush/redirect to IF/ID/EX, holds the pipe for BOOT_CYCLES
// after reset and keeps saturating stall/flush counters.
//   clk, rst                     : clock, asynchronous active-high reset
//   ex_valid/branch_ex/jump_ex   : EX instruction qualifiers
//   funct3_ex, br_eq, br_lt      : branch condition inputs
//   memread_ex, rd_ex            : EX load and its destination
//   rd_mem/rd_wb, regwrite_*     : later-stage destinations for forwarding
//   rs1_id/rs2_id, rs1_ex/rs2_ex : source registers in ID and EX
//   cnt_clr                      : synchronous clear of both counters
//   br_un, fwd_a_sel, fwd_b_sel  : comparator mode and operand selects
//   pc_sel, stall_*, flush_*     : pipeline control
//   illegal_br                   : B-type with reserved funct3 in EX
//   stall_cnt, flush_cnt         : saturating event counters
module ex_hazard_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             branch_ex,
  input  logic             jump_ex,
  input  logic [2:0]       funct3_ex,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             memread_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rd_mem,
  input  logic [4:0]       rd_wb,
  input  logic             regwrite_mem,
  input  logic             regwrite_wb,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rs1_ex,
  input  logic [4:0]       rs2_ex,
  input  logic             cnt_clr,
  output logic             br_un,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_sel,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             illegal_br,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned BootLast = (BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1;
  localparam int unsigned BootW    = (BootLast > 0) ? $clog2(BootLast + 1) : 1;
  // With no boot hold the FSM leaves reset directly in RUN.
  localparam ctrl_state_e StReset  = (BOOT_CYCLES == 0) ? StRun : StBoot;

  ctrl_state_e      state_q, state_d;
  logic [BootW-1:0] boot_cnt_q, boot_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic taken, br_illegal;
  logic in_boot, ex_live, redirect, load_use, lu_stall;

  br_resolve u_br_resolve (
    .funct3_i  (funct3_ex),
    .br_eq_i   (br_eq),
    .br_lt_i   (br_lt),
    .taken_o   (taken),
    .br_un_o   (br_un),
    .illegal_o (br_illegal)
  );

  // Reset is folded in so the hold outputs appear while rst is still asserted.
  assign in_boot  = rst | (state_q == StBoot);
  // EX only counts in RUN; in FLUSH it holds the squashed slot behind a redirect.
  assign ex_live  = ~rst & ex_valid & (state_q == StRun);
  assign redirect = ex_live & (jump_ex | (branch_ex & taken));
  assign load_use = ~in_boot & memread_ex & (rd_ex != 5'd0) &
                    ((rd_ex == rs1_id) | (rd_ex == rs2_id));
  // A redirect squashes the dependent instruction, so no stall is needed.
  assign lu_stall = load_use & ~redirect;

  always_comb begin
    pc_sel     = redirect;
    stall_if   = in_boot | lu_stall;
    stall_id   = in_boot | lu_stall;
    flush_id   = in_boot | redirect;
    flush_ex   = in_boot | redirect | lu_stall;
    illegal_br = ex_live & branch_ex & br_illegal;
    fwd_a_sel  = FWD_RF;
    fwd_b_sel  = FWD_RF;
    if (!in_boot) begin
      if (fwd_hit(regwrite_mem, rd_mem, rs1_ex)) begin
        fwd_a_sel = FWD_MEM;
      end else if (fwd_hit(regwrite_wb, rd_wb, rs1_ex)) begin
        fwd_a_sel = FWD_WB;
      end
      if (fwd_hit(regwrite_mem, rd_mem, rs2_ex)) begin
        fwd_b_sel = FWD_MEM;
      end else if (fwd_hit(regwrite_wb, rd_wb, rs2_ex)) begin
        fwd_b_sel = FWD_WB;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    unique case (state_q)
      StBoot: begin
        if (boot_cnt_q == BootW'(BootLast)) begin
          state_d = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q + BootW'(1);
        end
      end
      StRun:   if (redirect) state_d = StFlush;
      StFlush: state_d = StRun;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (lu_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StReset;
      boot_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ex_valid, branch_ex, jump_ex, br_eq, br_lt, memread_ex;
  logic [2:0] funct3_ex;
  logic [4:0] rd_ex, rd_mem, rd_wb, rs1_id, rs2_id, rs1_ex, rs2_ex;
  logic       regwrite_mem, regwrite_wb, cnt_clr;

  logic        br_un, pc_sel, stall_if, stall_id, flush_id, flush_ex, illegal_br;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;

  logic        br_un2, pc_sel2, stall_if2, stall_id2, flush_id2, flush_ex2, illegal_br2;
  logic [1:0]  fwd_a_sel2, fwd_b_sel2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .branch_ex(branch_ex), .jump_ex(jump_ex),
    .funct3_ex(funct3_ex), .br_eq(br_eq), .br_lt(br_lt), .memread_ex(memread_ex),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_mem(regwrite_mem),
    .regwrite_wb(regwrite_wb), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex),
    .rs2_ex(rs2_ex), .cnt_clr(cnt_clr), .br_un(br_un), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .pc_sel(pc_sel), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .illegal_br(illegal_br),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance for the saturation check; shares all inputs.
  ex_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .branch_ex(branch_ex), .jump_ex(jump_ex),
    .funct3_ex(funct3_ex), .br_eq(br_eq), .br_lt(br_lt), .memread_ex(memread_ex),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_mem(regwrite_mem),
    .regwrite_wb(regwrite_wb), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex),
    .rs2_ex(rs2_ex), .cnt_clr(cnt_clr), .br_un(br_un2), .fwd_a_sel(fwd_a_sel2),
    .fwd_b_sel(fwd_b_sel2), .pc_sel(pc_sel2), .stall_if(stall_if2), .stall_id(stall_id2),
    .flush_id(flush_id2), .flush_ex(flush_ex2), .illegal_br(illegal_br2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  typedef struct {
    string      name;
    logic       ev, br, jp, eq, lt, mr, rwm, rww;
    logic [2:0] f3;
    logic [4:0] rd_ex, rd_mem, rd_wb, rs1_id, rs2_id, rs1_ex, rs2_ex;
    logic [10:0] exp;  // {br_un, fwd_a, fwd_b, pc_sel, stall_if, stall_id, flush_id, flush_ex, ill}
  } vec_t;

  vec_t vecs[$];
  vec_t z, v;

  function automatic logic [10:0] outs();
    return {br_un, fwd_a_sel, fwd_b_sel, pc_sel, stall_if, stall_id, flush_id, flush_ex,
            illegal_br};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t a);
    ex_valid = a.ev; branch_ex = a.br; jump_ex = a.jp; funct3_ex = a.f3;
    br_eq = a.eq; br_lt = a.lt; memread_ex = a.mr;
    rd_ex = a.rd_ex; rd_mem = a.rd_mem; rd_wb = a.rd_wb;
    regwrite_mem = a.rwm; regwrite_wb = a.rww;
    rs1_id = a.rs1_id; rs2_id = a.rs2_id; rs1_ex = a.rs1_ex; rs2_ex = a.rs2_ex;
  endtask

  initial begin
    z = '{name: "idle", ev: 0, br: 0, jp: 0, eq: 0, lt: 0, mr: 0, rwm: 0, rww: 0, f3: 0,
          rd_ex: 0, rd_mem: 0, rd_wb: 0, rs1_id: 0, rs2_id: 0, rs1_ex: 0, rs2_ex: 0, exp: 0};
    cnt_clr = 1'b0;
    apply(z);

    v = z; v.name = "bne_taken"; v.ev = 1; v.br = 1; v.f3 = 3'b001;
    v.exp = 11'b0_00_00_1_00_11_0; vecs.push_back(v);
    v = z; v.name = "beq_not_taken"; v.ev = 1; v.br = 1; v.f3 = 3'b000;
    v.exp = 11'b0; vecs.push_back(v);
    v = z; v.name = "bltu_taken"; v.ev = 1; v.br = 1; v.f3 = 3'b110; v.lt = 1;
    v.exp = 11'b1_00_00_1_00_11_0; vecs.push_back(v);
    v = z; v.name = "bge_not_taken"; v.ev = 1; v.br = 1; v.f3 = 3'b101; v.lt = 1;
    v.exp = 11'b0; vecs.push_back(v);
    v = z; v.name = "bgeu_taken"; v.ev = 1; v.br = 1; v.f3 = 3'b111;
    v.exp = 11'b1_00_00_1_00_11_0; vecs.push_back(v);
    v = z; v.name = "illegal_010"; v.ev = 1; v.br = 1; v.f3 = 3'b010; v.eq = 1; v.lt = 1;
    v.exp = 11'b1_00_00_0_00_00_1; vecs.push_back(v);
    v = z; v.name = "illegal_011"; v.ev = 1; v.br = 1; v.f3 = 3'b011; v.eq = 1; v.lt = 1;
    v.exp = 11'b1_00_00_0_00_00_1; vecs.push_back(v);
    v = z; v.name = "bubble_branch"; v.br = 1; v.f3 = 3'b000; v.eq = 1;
    v.exp = 11'b0; vecs.push_back(v);
    v = z; v.name = "jal"; v.ev = 1; v.jp = 1;
    v.exp = 11'b0_00_00_1_00_11_0; vecs.push_back(v);
    v = z; v.name = "load_use_rs2"; v.mr = 1; v.rd_ex = 5; v.rs2_id = 5; v.rs1_id = 2;
    v.exp = 11'b0_00_00_0_11_01_0; vecs.push_back(v);
    v = z; v.name = "load_x0"; v.mr = 1; v.rd_ex = 0; v.rs1_id = 0; v.rs2_id = 0;
    v.exp = 11'b0; vecs.push_back(v);
    v = z; v.name = "fwd_a_mem"; v.rd_mem = 7; v.rd_wb = 7; v.rwm = 1; v.rww = 1; v.rs1_ex = 7;
    v.exp = 11'b0_01_00_0_00_00_0; vecs.push_back(v);
    v = z; v.name = "fwd_a_wb"; v.rd_mem = 7; v.rd_wb = 7; v.rww = 1; v.rs1_ex = 7;
    v.exp = 11'b0_10_00_0_00_00_0; vecs.push_back(v);
    v = z; v.name = "fwd_a_rs0"; v.rd_mem = 7; v.rd_wb = 7; v.rwm = 1; v.rww = 1;
    v.exp = 11'b0; vecs.push_back(v);
    v = z; v.name = "fwd_x0"; v.rwm = 1; v.rww = 1;
    v.exp = 11'b0; vecs.push_back(v);
    v = z; v.name = "fwd_b_wb"; v.rd_mem = 4; v.rd_wb = 3; v.rwm = 1; v.rww = 1;
    v.rs1_ex = 4; v.rs2_ex = 3;
    v.exp = 11'b0_01_10_0_00_00_0; vecs.push_back(v);
    v = z; v.name = "redirect_over_lu"; v.ev = 1; v.br = 1; v.eq = 1; v.mr = 1;
    v.rd_ex = 9; v.rs1_id = 9;
    v.exp = 11'b0_00_00_1_00_11_0; vecs.push_back(v);

    // Reset and boot hold.
    #2;
    chk("in_reset_outs", outs(), 11'b0_00_00_0_11_11_0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #2 chk("boot_cycle1", outs(), 11'b0_00_00_0_11_11_0);
    @(negedge clk);
    #2 chk("boot_cycle2", outs(), 11'b0_00_00_0_11_11_0);
    @(negedge clk);
    #2 chk("run_idle", outs(), 11'b0);

    // Table: each vector applied in RUN, then one idle cycle so FLUSH returns to RUN.
    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #2 chk(vecs[i].name, outs(), vecs[i].exp);
      if (vecs[i].exp[5]) exp_flush++;
      if (vecs[i].exp[4]) exp_stall++;
      @(negedge clk);
      apply(z);
      #2 chk({vecs[i].name, "_stall_cnt"}, stall_cnt, exp_stall);
      chk({vecs[i].name, "_flush_cnt"}, flush_cnt, exp_flush);
      @(negedge clk);
    end

    // Redirect, then in FLUSH a jump is ignored while load-use still stalls.
    @(negedge clk);
    v = z; v.ev = 1; v.br = 1; v.f3 = 3'b001; apply(v);
    #2 chk("seq_bne_redirect", outs(), 11'b0_00_00_1_00_11_0);
    @(negedge clk);
    v = z; v.ev = 1; v.jp = 1; v.mr = 1; v.rd_ex = 6; v.rs1_id = 6; apply(v);
    #2 chk("flush_jump_masked", outs(), 11'b0_00_00_0_11_01_0);
    @(negedge clk);
    apply(z);
    exp_flush++;
    exp_stall++;
    #2 chk("flush_seq_flush_cnt", flush_cnt, exp_flush);
    chk("flush_seq_stall_cnt", stall_cnt, exp_stall);
    chk("back_in_run", outs(), 11'b0);

    // Clear wins over a same-cycle increment, then saturate the 2-bit counter.
    @(negedge clk);
    v = z; v.mr = 1; v.rd_ex = 5; v.rs2_id = 5; apply(v);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #2 chk("clr_prio_stall_cnt", stall_cnt, 0);
    chk("clr_prio_flush_cnt", flush_cnt, 0);
    chk("clr_prio_stall_cnt2", stall_cnt2, 0);
    repeat (5) @(negedge clk);
    apply(z);
    #2 chk("five_stalls_cnt16", stall_cnt, 5);
    chk("five_stalls_sat_cnt2", stall_cnt2, 3);

    // Reset mid-operation: boot outputs immediately, redirect dropped.
    @(negedge clk);
    v = z; v.ev = 1; v.jp = 1; apply(v);
    #2 chk("pre_reset_redirect", pc_sel, 1);
    rst = 1'b1;
    #1 chk("mid_reset_outs", outs(), 11'b0_00_00_0_11_11_0);
    chk("mid_reset_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #2 chk("post_reset_boot", outs(), 11'b0_00_00_0_11_11_0);
    chk("post_reset_flush_cnt", flush_cnt, 0);
    apply(z);
    repeat (2) @(negedge clk);
    #2 chk("post_reset_run", outs(), 11'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
